apb_spi_csr: RTL and testbench



---
 rtl/apb_spi_csr_pkg.sv | 37 +++
 rtl/apb_spi_csr_fifo.sv | 52 +++++
 rtl/apb_spi_csr.sv | 173 +++++++++++++++++
 tb/tb_apb_spi_csr.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_csr_pkg.sv
// Shared register map, field indices and FSM state type
// for the APB SPI register front end.
package apb_spi_pkg;

  localparam int ADDR_DATA   = 0;
  localparam int ADDR_STATUS = 1;
  localparam int ADDR_CTRL   = 2;
  localparam int ADDR_CLKDIV = 3;
  localparam int ADDR_LEVEL  = 4;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CPOL   = 1;
  localparam int CTRL_CPHA   = 2;
  localparam int CTRL_LSB    = 3;
  localparam int CTRL_IE_RX  = 4;
  localparam int CTRL_IE_TX  = 5;
  localparam int CTRL_IE_OVF = 6;
  localparam int CTRL_W      = 7;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_RX_OVF   = 4;
  localparam int ST_BUSY     = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT
  } apb_state_e;

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'hF : n[3:0];
  endfunction

endpackage

// File: rtl/apb_spi_csr_fifo.sv
// First-word fall-through FIFO; a full FIFO still accepts
// a push when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_push && w_pop)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

endmodule

// File: rtl/apb_spi_csr.sv
// APB register front end for the SPI engine. Owns the TX/RX
// FIFOs and stretches DATA accesses on FIFO back-pressure.
module apb_spi_csr
  import apb_spi_pkg::*;
#(
  parameter int AWIDTH       = 4,
  parameter int DWIDTH       = 8,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [AWIDTH-1:0] PADDR,
  input  logic [DWIDTH-1:0] PWDATA,
  output logic [DWIDTH-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DWIDTH-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              busy,
  output logic              ctrl_en,
  output logic              ctrl_cpol,
  output logic              ctrl_cpha,
  output logic              ctrl_lsb,
  output logic [DWIDTH-1:0] clk_div,
  output logic              irq
);
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;
  localparam int WCW = (WAIT_TIMEOUT > 0) ?
                       $clog2(WAIT_TIMEOUT + 1) : 1;

  apb_state_e        r_state;
  logic [WCW-1:0]    r_wait_cnt;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DWIDTH-1:0] r_clkdiv;
  logic              r_ovf;
  logic              r_irq;

  logic              w_tx_full, w_tx_empty;
  logic              w_rx_full, w_rx_empty;
  logic [TCW-1:0]    w_tx_cnt;
  logic [RCW-1:0]    w_rx_cnt;
  logic [DWIDTH-1:0] w_rx_head, w_rdata;
  logic [5:0]        w_status;
  logic [7:0]        w_level;
  logic              w_acc, w_bad;
  logic              w_sel_data, w_sel_status, w_sel_ctrl;
  logic              w_sel_clkdiv, w_sel_level;
  logic              w_tx_pop, w_tx_push, w_rx_pop;
  logic              w_blocked, w_tmo, w_done;
  logic              w_err, w_fire, w_wfire;

  assign w_acc        = PSEL & PENABLE;
  assign w_sel_data   = (PADDR == AWIDTH'(ADDR_DATA));
  assign w_sel_status = (PADDR == AWIDTH'(ADDR_STATUS));
  assign w_sel_ctrl   = (PADDR == AWIDTH'(ADDR_CTRL));
  assign w_sel_clkdiv = (PADDR == AWIDTH'(ADDR_CLKDIV));
  assign w_sel_level  = (PADDR == AWIDTH'(ADDR_LEVEL));
  assign w_bad        = (PADDR > AWIDTH'(ADDR_LEVEL));

  // A TX pop on the same edge frees room, so it unblocks a write.
  assign w_tx_pop  = tx_ready & ~w_tx_empty;
  assign w_blocked = w_sel_data &
                     (PWRITE ? (w_tx_full & ~w_tx_pop)
                             : w_rx_empty);
  assign w_tmo     = (r_wait_cnt == WCW'(WAIT_TIMEOUT));
  assign w_done    = ~w_blocked | w_tmo;

  assign PREADY  = w_acc & w_done & ~PRESET;
  assign w_err   = w_blocked | w_bad | (PWRITE & w_sel_level);
  assign PSLVERR = PREADY & w_err;
  assign w_fire  = PREADY & ~w_err;
  assign w_wfire = w_fire & PWRITE;
  assign PRDATA  = (w_fire & ~PWRITE) ? w_rdata : '0;

  assign w_tx_push = w_wfire & w_sel_data;
  assign w_rx_pop  = w_fire & ~PWRITE & w_sel_data;

  sync_fifo #(.WIDTH(DWIDTH), .DEPTH(TX_DEPTH)) u_tx (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_push  (w_tx_push),
    .i_din   (PWDATA),
    .i_pop   (tx_ready),
    .o_dout  (tx_data),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_cnt)
  );

  sync_fifo #(.WIDTH(DWIDTH), .DEPTH(RX_DEPTH)) u_rx (
    .i_clk   (PCLK),
    .i_rst   (PRESET),
    .i_push  (rx_valid),
    .i_din   (rx_data),
    .i_pop   (w_rx_pop),
    .o_dout  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_cnt)
  );

  assign w_status = {busy, r_ovf, w_rx_empty,
                     w_rx_full, w_tx_empty, w_tx_full};
  assign w_level  = {sat4(int'(w_rx_cnt)),
                     sat4(int'(w_tx_cnt))};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_data:   w_rdata = w_rx_head;
      w_sel_status: w_rdata = DWIDTH'(w_status);
      w_sel_ctrl:   w_rdata = DWIDTH'(r_ctrl);
      w_sel_clkdiv: w_rdata = r_clkdiv;
      w_sel_level:  w_rdata = DWIDTH'(w_level);
      default:      w_rdata = '0;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_ctrl     <= '0;
      r_clkdiv   <= '0;
      r_ovf      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      case (r_state)
        IDLE:
          if (PSEL && !PENABLE) r_state <= ACCESS;
          else if (w_acc && !w_done) r_state <= WAIT;
        ACCESS:
          if (w_acc) r_state <= w_done ? IDLE : WAIT;
          else if (!PSEL) r_state <= IDLE;
        WAIT:
          if (!w_acc || w_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      r_wait_cnt <= (w_acc && !w_done) ?
                    r_wait_cnt + WCW'(1) : '0;
      if (w_wfire && w_sel_ctrl)
        r_ctrl <= PWDATA[CTRL_W-1:0];
      if (w_wfire && w_sel_clkdiv)
        r_clkdiv <= PWDATA;
      // A drop on the clearing edge keeps the flag set.
      if (rx_valid && w_rx_full && !w_rx_pop)
        r_ovf <= 1'b1;
      else if (w_wfire && w_sel_status && PWDATA[ST_RX_OVF])
        r_ovf <= 1'b0;
      r_irq <= (r_ctrl[CTRL_IE_RX] & ~w_rx_empty) |
               (r_ctrl[CTRL_IE_TX] & w_tx_empty) |
               (r_ctrl[CTRL_IE_OVF] & r_ovf);
    end
  end

  assign tx_valid  = ~w_tx_empty;
  assign ctrl_en   = r_ctrl[CTRL_EN];
  assign ctrl_cpol = r_ctrl[CTRL_CPOL];
  assign ctrl_cpha = r_ctrl[CTRL_CPHA];
  assign ctrl_lsb  = r_ctrl[CTRL_LSB];
  assign clk_div   = r_clkdiv;
  assign irq       = r_irq;

endmodule

// File: tb/tb_apb_spi_csr.sv
// Bench for apb_spi_csr: queue-based register/FIFO model checked
// every cycle, plus directed transfers with literal results.
module tb_apb_spi_csr;
  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam int WT  = 16;

  logic       PCLK = 0;
  logic       PRESET = 1;
  logic       PSEL = 0, PENABLE = 0, PWRITE = 0;
  logic [3:0] PADDR = 0;
  logic [7:0] PWDATA = 0;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 0;
  logic [7:0] rx_data = 0;
  logic       rx_valid = 0;
  logic       busy = 0;
  logic       ctrl_en, ctrl_cpol, ctrl_cpha, ctrl_lsb;
  logic [7:0] clk_div;
  logic       irq;

  apb_spi_csr #(
    .AWIDTH(4), .DWIDTH(8), .TX_DEPTH(TXD),
    .RX_DEPTH(RXD), .WAIT_TIMEOUT(WT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .ctrl_en(ctrl_en), .ctrl_cpol(ctrl_cpol),
    .ctrl_cpha(ctrl_cpha), .ctrl_lsb(ctrl_lsb),
    .clk_div(clk_div), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  bit bg = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Model state: FIFOs as queues, registers as plain values.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [6:0] m_ctrl = 0;
  logic [7:0] m_div = 0;
  bit         m_ovf = 0, m_irq = 0;
  int         m_wait = 0;

  bit         e_acc, e_blk, e_done, e_rdy, e_err, e_fire, e_txpop;
  logic [7:0] e_rdata;

  task automatic calc();
    int a, lt, lr;
    a = int'(PADDR);
    e_acc = PSEL && PENABLE;
    e_txpop = tx_ready && txq.size() > 0;
    e_blk = 0;
    if (a == 0)
      e_blk = PWRITE ? (txq.size() == TXD && !e_txpop)
                     : (rxq.size() == 0);
    e_done = !e_blk || m_wait == WT;
    e_rdy = e_acc && e_done && !PRESET;
    e_err = e_rdy && (e_blk || a > 4 || (PWRITE && a == 4));
    e_fire = e_rdy && !e_err;
    e_rdata = 0;
    lt = txq.size() > 15 ? 15 : txq.size();
    lr = rxq.size() > 15 ? 15 : rxq.size();
    if (e_fire && !PWRITE)
      case (a)
        0: e_rdata = rxq[0];
        1: e_rdata = 8'({busy, m_ovf, rxq.size() == 0,
                         rxq.size() == RXD, txq.size() == 0,
                         txq.size() == TXD});
        2: e_rdata = 8'(m_ctrl);
        3: e_rdata = m_div;
        default: e_rdata = 8'(lr * 16 + lt);
      endcase
  endtask

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      txq.delete(); rxq.delete();
      m_ctrl = 0; m_div = 0; m_ovf = 0; m_irq = 0; m_wait = 0;
    end else begin
      bit rxpop, drop;
      int a;
      calc();
      a = int'(PADDR);
      m_irq = (m_ctrl[4] && rxq.size() > 0) ||
              (m_ctrl[5] && txq.size() == 0) ||
              (m_ctrl[6] && m_ovf);
      rxpop = e_fire && !PWRITE && a == 0;
      drop = rx_valid && rxq.size() == RXD && !rxpop;
      if (e_txpop) void'(txq.pop_front());
      if (e_fire && PWRITE && a == 0) txq.push_back(PWDATA);
      if (rxpop) void'(rxq.pop_front());
      if (rx_valid && !drop) rxq.push_back(rx_data);
      if (e_fire && PWRITE && a == 1 && PWDATA[4]) m_ovf = 0;
      if (drop) m_ovf = 1;
      if (e_fire && PWRITE && a == 2) m_ctrl = PWDATA[6:0];
      if (e_fire && PWRITE && a == 3) m_div = PWDATA;
      m_wait = (e_acc && !e_done) ? m_wait + 1 : 0;
    end
  end

  always @(negedge PCLK) begin
    calc();
    chk("pready", 32'(PREADY), 32'(e_rdy));
    chk("pslverr", 32'(PSLVERR), 32'(e_err));
    if (!(e_rdy && PWRITE)) chk("prdata", 32'(PRDATA), 32'(e_rdata));
    chk("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
    if (txq.size() > 0) chk("tx_data", 32'(tx_data), 32'(txq[0]));
    chk("ctrl", 32'({ctrl_lsb, ctrl_cpha, ctrl_cpol, ctrl_en}),
        32'(m_ctrl[3:0]));
    chk("clk_div", 32'(clk_div), 32'(m_div));
    chk("irq", 32'(irq), 32'(m_irq));
  end

  task automatic step();
    @(posedge PCLK);
    #1;
    if (bg) begin
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      busy     = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic apb(input bit wr, input logic [3:0] a,
                     input logic [7:0] wd, input int rxv_at,
                     output logic [7:0] rd, output bit er,
                     output int waits);
    PSEL = 1; PENABLE = 0; PWRITE = wr; PADDR = a; PWDATA = wd;
    rd = 0; er = 0;
    step();
    PENABLE = 1;
    waits = 0;
    forever begin
      if (rxv_at >= 0) begin
        rx_valid = (waits == rxv_at);
        rx_data = 8'h5A;
      end
      @(negedge PCLK);
      if (PREADY) begin
        rd = PRDATA; er = PSLVERR;
        break;
      end
      waits++;
      if (waits > WT + 4) begin
        checks++; errors++;
        $display("FAIL apb_timeout actual=%0d required<=%0d",
                 waits, WT);
        break;
      end
      step();
    end
    step();
    PSEL = 0; PENABLE = 0;
    if (rxv_at >= 0) rx_valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    bit er;
    int w;
    repeat (2) @(posedge PCLK);
    #3 PRESET = 0;
    @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 0);
    chk("rst_prdata", 32'(PRDATA), 0);
    chk("rst_outs", 32'({irq, tx_valid, ctrl_en, PSLVERR}), 0);
    chk("rst_clkdiv", 32'(clk_div), 0);
    step();

    apb(0, 1, 0, -1, rd, er, w);
    chk("status_rst", 32'(rd), 32'h0A);
    chk("status_nowait", 32'(w), 0);

    apb(1, 0, 8'hA5, -1, rd, er, w);
    apb(1, 0, 8'h3C, -1, rd, er, w);
    apb(0, 4, 0, -1, rd, er, w);
    chk("level_two", 32'(rd), 32'h02);
    tx_ready = 1;
    step();
    tx_ready = 0;
    @(negedge PCLK);
    chk("tx_head", 32'(tx_data), 32'h3C);
    step();

    apb(0, 0, 0, -1, rd, er, w);
    chk("tmo_waits", 32'(w), 16);
    chk("tmo_err", 32'(er), 1);
    chk("tmo_data", 32'(rd), 0);
    apb(0, 0, 0, 3, rd, er, w);
    chk("late_waits", 32'(w), 4);
    chk("late_data", 32'(rd), 32'h5A);
    chk("late_err", 32'(er), 0);

    apb(1, 2, 8'h40, -1, rd, er, w);
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1; rx_data = 8'(8'h10 + i);
      step();
    end
    rx_valid = 0;
    apb(0, 1, 0, -1, rd, er, w);
    chk("ovf_set", 32'(rd[4]), 1);
    chk("ovf_irq", 32'(irq), 1);
    apb(1, 1, 8'h10, -1, rd, er, w);
    apb(0, 1, 0, -1, rd, er, w);
    chk("ovf_clr", 32'(rd[4]), 0);
    chk("ovf_irq_clr", 32'(irq), 0);
    apb(0, 0, 0, -1, rd, er, w);
    chk("rx_first", 32'(rd), 32'h10);
    for (int i = 0; i < 7; i++) apb(0, 0, 0, -1, rd, er, w);
    chk("rx_last", 32'(rd), 32'h17);

    apb(1, 3, 8'h55, -1, rd, er, w);
    chk("clkdiv_wr", 32'(clk_div), 32'h55);
    apb(1, 4, 8'hFF, -1, rd, er, w);
    chk("level_wr_err", 32'(er), 1);
    apb(0, 4, 0, -1, rd, er, w);
    chk("level_keep", 32'(rd), 32'h01);
    apb(1, 7, 8'hFF, -1, rd, er, w);
    chk("bad_wr_err", 32'(er), 1);
    apb(0, 7, 0, -1, rd, er, w);
    chk("bad_rd", 32'({er, rd}), 32'h100);
    chk("clkdiv_keep", 32'(clk_div), 32'h55);

    apb(1, 2, 8'h01, -1, rd, er, w);
    chk("ctrl_en_set", 32'(ctrl_en), 1);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 0;
    step();
    PENABLE = 1;
    repeat (3) step();
    #2 PRESET = 1;
    #1;
    chk("rst_mid_pready", 32'(PREADY), 0);
    chk("rst_mid_fifo", 32'(tx_valid), 0);
    chk("rst_mid_ctrl", 32'(ctrl_en), 0);
    PSEL = 0; PENABLE = 0;
    step();
    step();
    PRESET = 0;
    @(negedge PCLK);
    chk("rst_rel_ctrl", 32'({ctrl_en, clk_div}), 0);
    step();
    apb(0, 1, 0, -1, rd, er, w);
    chk("rst_rel_status", 32'(rd), 32'h0A);

    bg = 1;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) a = 0;
      apb($urandom_range(0, 1) == 1, a, 8'($urandom),
          -1, rd, er, w);
      if ($urandom_range(0, 3) == 0) step();
    end
    bg = 0;
    tx_ready = 0; rx_valid = 0;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
